// File: rtl/mlsd_sched_pkg.sv
// Shared types and sizing helpers for the MLSD decision scheduler.
package mlsd_sched_pkg;

  // Scheduler phases: accept a frame, stream requests, wait for the last
  // distance, publish the decisions.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  localparam int DEF_NUM_CHANNELS = 16;
  localparam int DEF_NBIT         = 1;
  localparam int DEF_CODE_BW      = 10;

  // Number of hypotheses tested per channel for a given decision width.
  function automatic int num_hyp(input int nbit);
    return 1 << nbit;
  endfunction

  // Index width for a table of n entries, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mlsd_min_tracker.sv
// Running arg-min over the hypotheses of one channel. The first hypothesis
// seeds the minimum; later ones replace it only when strictly smaller, so
// ties resolve to the lowest hypothesis index.
module mlsd_min_tracker
  import mlsd_sched_pkg::*;
#(
  parameter int nbit         = DEF_NBIT,
  parameter int codeBitwidth = DEF_CODE_BW
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear_i,
  input  logic                           sample_valid_i,
  input  logic [nbit-1:0]                hyp_i,
  input  logic signed [codeBitwidth-1:0] dist_i,
  output logic [nbit-1:0]                result_o
);

  logic signed [codeBitwidth-1:0] best_dist_q, best_dist_d;
  logic [nbit-1:0]                best_hyp_q,  best_hyp_d;

  // Compare the incoming distance against the running minimum.
  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    best_dist_d = best_dist_q;
    best_hyp_d  = best_hyp_q;
    if (sample_valid_i) begin
      if (hyp_i == '0) begin
        best_dist_d = dist_i;
        best_hyp_d  = '0;
      end else if (dist_i < best_dist_q) begin
        best_dist_d = dist_i;
        best_hyp_d  = hyp_i;
      end
    end
  end

  // The post-update winner lets the caller capture a channel's decision in
  // the same cycle its last hypothesis arrives.
  assign result_o = best_hyp_d;

  // Running-minimum registers; a flush discards any partial channel.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_dist_q <= '0;
      best_hyp_q  <= '0;
    end else if (clear_i) begin
      best_dist_q <= '0;
      best_hyp_q  <= '0;
    end else begin
      best_dist_q <= best_dist_d;
      best_hyp_q  <= best_hyp_d;
    end
  end

endmodule

// File: rtl/mlsd_decision_sched.sv
// MLSD decision scheduler: for each accepted frame it walks every
// (channel, hypothesis) pair through the shared external distance unit,
// keeps the arg-min per channel, and publishes all decisions at once.
module mlsd_decision_sched
  import mlsd_sched_pkg::*;
#(
  parameter int numChannels  = DEF_NUM_CHANNELS,
  parameter int nbit         = DEF_NBIT,
  parameter int codeBitwidth = DEF_CODE_BW
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic                                 frame_valid,
  output logic                                 frame_ready,
  output logic                                 dist_req,
  output logic [$clog2(numChannels)-1:0]       dist_ch,
  output logic [nbit-1:0]                      dist_hyp,
  input  logic signed [codeBitwidth-1:0]       dist_in,
  output logic [numChannels-1:0][nbit-1:0]     predict_bits,
  output logic                                 bits_valid,
  output logic                                 busy
);

  localparam int H    = num_hyp(nbit);
  localparam int CH_W = $clog2(numChannels);

  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(numChannels - 1);
  localparam logic [nbit-1:0] LAST_HYP = nbit'(H - 1);

  sched_state_e state_q, state_d;

  logic [CH_W-1:0] ch_q,  ch_d;
  logic [nbit-1:0] hyp_q, hyp_d;

  // One-deep tag: which request the current dist_in answers.
  logic            tag_valid_q, tag_valid_d;
  logic [CH_W-1:0] tag_ch_q,    tag_ch_d;
  logic [nbit-1:0] tag_hyp_q,   tag_hyp_d;

  logic [numChannels-1:0][nbit-1:0] shadow_q,  shadow_d;
  logic [numChannels-1:0][nbit-1:0] predict_q, predict_d;

  logic            last_req;
  logic [nbit-1:0] trk_result;

  assign last_req = (state_q == ST_ISSUE) && (ch_q == LAST_CH) && (hyp_q == LAST_HYP);

  // Status and request outputs decode directly from the state so reset
  // forces them to their idle values.
  assign frame_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign bits_valid  = (state_q == ST_DONE);
  assign dist_req    = (state_q == ST_ISSUE);
  assign dist_ch     = dist_req ? ch_q  : '0;
  assign dist_hyp    = dist_req ? hyp_q : '0;
  assign predict_bits = predict_q;

  // Next-state logic; flush overrides everything, including an accept.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (frame_valid) state_d = ST_ISSUE;
      ST_ISSUE: if (last_req)    state_d = ST_DRAIN;
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // Request counters: hypothesis inner, channel outer, wrapping to zero
  // after the final request of the frame.
  always_comb begin
    ch_d  = ch_q;
    hyp_d = hyp_q;
    if (state_q == ST_ISSUE) begin
      hyp_d = hyp_q + nbit'(1);
      if (hyp_q == LAST_HYP) begin
        ch_d = (ch_q == LAST_CH) ? '0 : ch_q + CH_W'(1);
      end
    end
    if (flush) begin
      ch_d  = '0;
      hyp_d = '0;
    end
  end

  // Tag pipeline and shadow capture of each finished channel.
  always_comb begin
    tag_valid_d = dist_req && !flush;
    tag_ch_d    = flush ? '0 : dist_ch;
    tag_hyp_d   = flush ? '0 : dist_hyp;

    shadow_d = shadow_q;
    if (tag_valid_q && (tag_hyp_q == LAST_HYP)) begin
      shadow_d[tag_ch_q] = trk_result;
    end
    if (flush) shadow_d = '0;

    // The last channel completes on the same edge that enters DONE, so the
    // published word is taken from the shadow's next value.
    predict_d = predict_q;
    if ((state_q == ST_DRAIN) && !flush) predict_d = shadow_d;
  end

  mlsd_min_tracker #(
    .nbit         (nbit),
    .codeBitwidth (codeBitwidth)
  ) u_min_tracker (
    .clk            (clk),
    .rst            (rst),
    .clear_i        (flush),
    .sample_valid_i (tag_valid_q),
    .hyp_i          (tag_hyp_q),
    .dist_i         (dist_in),
    .result_o       (trk_result)
  );

  // Control, pipeline and decision registers.
  // NOTE: the shadow and output arrays are small flop banks, not RAM, so
  // they take the asynchronous reset like any other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ch_q        <= '0;
      hyp_q       <= '0;
      tag_valid_q <= 1'b0;
      tag_ch_q    <= '0;
      tag_hyp_q   <= '0;
      shadow_q    <= '0;
      predict_q   <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      hyp_q       <= hyp_d;
      tag_valid_q <= tag_valid_d;
      tag_ch_q    <= tag_ch_d;
      tag_hyp_q   <= tag_hyp_d;
      shadow_q    <= shadow_d;
      predict_q   <= predict_d;
    end
  end

endmodule

// File: doc/mlsd_decision_sched.md
MLSD_DECISION_SCHED -- requirements
Module: mlsd_decision_sched

Interface
REQ-001 SHALL have parameter numChannels, default 16, number of channels per frame.
REQ-002 SHALL have parameter nbit, default 1, bits per decision; H = 2**nbit hypotheses.
REQ-003 SHALL have parameter codeBitwidth, default 10, signed distance width.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  synchronous abort of the frame in progress.
REQ-007 SHALL have port frame_valid  input  1  new frame of codes available.
REQ-008 SHALL have port frame_ready  output  1  scheduler idle and able to accept a frame.
REQ-009 SHALL have port dist_req  output  1  request to the shared distance unit.
REQ-010 SHALL have port dist_ch  output  $clog2(numChannels)  channel index of the request.
REQ-011 SHALL have port dist_hyp  output  nbit  hypothesis index of the request.
REQ-012 SHALL have port dist_in  input  codeBitwidth signed  distance, valid exactly one cycle after its dist_req.
REQ-013 SHALL have port predict_bits  output  [numChannels][nbit]  registered decisions.
REQ-014 SHALL have port bits_valid  output  1  one-cycle pulse when predict_bits is updated.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement the states IDLE, ISSUE, DRAIN and DONE.
REQ-017 SHALL drive frame_ready high only in IDLE; a frame is accepted on a clock edge with frame_valid & frame_ready, and IDLE then moves to ISSUE.
REQ-018 SHALL, in ISSUE, assert dist_req every cycle for numChannels*H consecutive cycles, with the channel loop outer and the hypothesis loop inner: (ch0,h0), (ch0,h1) ... (chN-1,hH-1).
REQ-019 SHALL move from ISSUE to DRAIN after issuing the last request, and SHALL hold dist_req low in DRAIN.
REQ-020 SHALL move from DRAIN to DONE and then unconditionally from DONE to IDLE.
REQ-021 SHALL drive dist_ch and dist_hyp to 0 whenever dist_req is low.
REQ-022 SHALL use a one-deep pipeline to tag each dist_in with its (channel, hypothesis).
REQ-023 SHALL, on hypothesis 0 of a channel, load best_dist = dist_in and best_hyp = 0.
REQ-024 SHALL, for each later hypothesis, replace best_dist and best_hyp only when dist_in < best_dist (signed, strict); ties keep the lower index.
REQ-025 SHALL write a channel's final best_hyp, taken after its last hypothesis, into a shadow array.
REQ-026 SHALL copy the shadow array to predict_bits at the edge entering DONE, and SHALL assert bits_valid throughout DONE.
REQ-027 SHALL hold predict_bits unchanged at all other times, including while the next frame is processing.
REQ-028 SHALL give a latency of numChannels*H+2 cycles from the accept edge to bits_valid; for the defaults this is 34.
REQ-029 SHALL ignore frame_valid while busy, with no queuing.
REQ-030 SHALL, on flush in any state, go to IDLE at the next edge, emit no bits_valid, leave predict_bits unchanged and clear the working registers.
REQ-031 SHALL give flush priority over a simultaneous frame_valid in IDLE, so that no frame is accepted.
REQ-032 SHALL support a new frame being accepted in the cycle immediately after DONE.
REQ-033 SHALL wrap the channel and hypothesis counters to 0 after the last request.

Reset
REQ-034 SHALL, on rst assertion, asynchronously set the state to IDLE and clear predict_bits, the shadow array, best_dist, best_hyp, all counters and the pipeline tag.
REQ-035 SHALL hold the following outputs in reset: bits_valid=0, dist_req=0, busy=0, frame_ready=1.
REQ-036 SHALL, on rst mid-frame, discard the frame, clear the outputs and emit no bits_valid after release.

Structure
REQ-037 SHALL place the state enum and the H/index-width localparams in a shared package mlsd_sched_pkg.
REQ-038 SHALL implement the per-channel compare/update (REQ-023..REQ-024) as one sub-module, mlsd_min_tracker.
REQ-039 SHALL NOT instantiate the distance unit; it is external and shared.

Verification
REQ-040 SHALL cover a basic frame with nbit=1 and N=16:
- stimulus: ch k returns h0=10, h1=3 for even k, and h0=3, h1=10 for odd k;
- response: predict_bits alternates 1,0,... and bits_valid fires at cycle 34 for exactly one cycle.
REQ-041 SHALL cover a tie: h0=h1=-5 on every channel -> all predict_bits = 0.
REQ-042 SHALL cover signed values with nbit=2: distances {7,-2,-8,-8} -> decision 2 on each channel.
REQ-043 SHALL cover flush at cycle 10 of a frame:
- response: no bits_valid, previous predict_bits retained, frame_ready high at cycle 11;
- a frame_valid asserted simultaneously with flush is not accepted.
REQ-044 SHALL cover back-to-back frames:
- stimulus: frame_valid held high;
- response: frames are accepted every 35 cycles, bits_valid pulses at 34 and 69, and frame_valid is ignored while busy.
REQ-045 SHALL cover rst asserted at cycle 20:
- response: predict_bits=0 and state IDLE immediately, and no bits_valid after release.
